// File: rtl/mc8051_biu_mc_pkg.sv
// Shared types and constants for the multi-channel 8051 bus interface unit.
package mc8051_biu_mc_pkg;

  typedef enum logic [1:0] {
    BIU_IDLE   = 2'd0,
    BIU_ACCESS = 2'd1,
    BIU_DONE   = 2'd2,
    BIU_ERR    = 2'd3
  } biu_state_e;

  localparam logic ARB_FIXED_MODE = 1'b0;
  localparam logic ARB_RR_MODE    = 1'b1;

  // Index width for n channels; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mc8051_biu_mc_arb.sv
// NCH-wide request arbiter: fixed priority or round-robin from an internal pointer.
module mc8051_biu_arb
  import mc8051_biu_mc_pkg::*;
#(
  parameter int NCH = 2,
  localparam int IW = idx_w(NCH)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NCH-1:0] req,
  input  logic           mode,
  input  logic           adv,
  input  logic [IW-1:0]  adv_idx,
  output logic [NCH-1:0] grant,
  output logic [IW-1:0]  grant_idx,
  output logic           grant_vld
);

  logic [IW-1:0] ptr;
  int            idx;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant     = '0;
    idx       = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (mode == ARB_RR_MODE) ? (int'(ptr) + k) % NCH : k;
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      grant[c] = grant_vld && (grant_idx == IW'(c));
    end
  end

  // The next search starts just past the channel that was last served.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (adv_idx == IW'(NCH - 1)) ? '0 : adv_idx + IW'(1);
    end
  end

endmodule

// File: rtl/mc8051_biu_mc.sv
// Multi-channel handshaked 8051 bus interface unit: arbitrates NCH requesters
// onto one memory/SFR bus with wait states and an optional access timeout.
module mc8051_biu_mc
  import mc8051_biu_mc_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int ARB_RR  = 0,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH-1:0]    i_req,
  input  logic [NCH-1:0]    i_req_we,
  input  logic [NCH-1:0]    i_req_psen,
  input  logic [NCH-1:0]    i_req_sfr,
  input  logic [NCH*AW-1:0] i_req_addr,
  input  logic [NCH*DW-1:0] i_req_wdata,
  output logic [NCH-1:0]    o_ack,
  output logic [NCH-1:0]    o_err,
  output logic [DW-1:0]     o_rdata,
  output logic              o_busy,
  output logic              mem_sfr_n,
  output logic              mem_we_n,
  output logic              mem_rd_n,
  output logic              mem_psen_n,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_data_rdy,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int IW = idx_w(NCH);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  biu_state_e     state;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  gnt_idx;
  logic [NCH-1:0] gnt_oh;
  logic           acc_we;

  logic [NCH-1:0] arb_grant;
  logic [IW-1:0]  arb_idx;
  logic           arb_vld;

  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic           sel_we;
  logic           sel_psen;
  logic           sel_sfr;

  mc8051_biu_arb #(
    .NCH(NCH)
  ) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (i_req),
    .mode     ((ARB_RR != 0) ? ARB_RR_MODE : ARB_FIXED_MODE),
    .adv      ((state == BIU_DONE) || (state == BIU_ERR)),
    .adv_idx  (gnt_idx),
    .grant    (arb_grant),
    .grant_idx(arb_idx),
    .grant_vld(arb_vld)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    sel_psen  = 1'b0;
    sel_sfr   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (arb_grant[c]) begin
        sel_addr  = i_req_addr[c*AW +: AW];
        sel_wdata = i_req_wdata[c*DW +: DW];
        sel_we    = i_req_we[c];
        sel_psen  = i_req_psen[c];
        sel_sfr   = i_req_sfr[c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= BIU_IDLE;
      cnt        <= '0;
      gnt_idx    <= '0;
      gnt_oh     <= '0;
      acc_we     <= 1'b0;
      o_ack      <= '0;
      o_err      <= '0;
      o_rdata    <= '0;
      o_busy     <= 1'b0;
      mem_sfr_n  <= 1'b1;
      mem_we_n   <= 1'b1;
      mem_rd_n   <= 1'b1;
      mem_psen_n <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      o_ack <= '0;
      o_err <= '0;
      case (state)
        BIU_IDLE: begin
          if (arb_vld) begin
            state      <= BIU_ACCESS;
            o_busy     <= 1'b1;
            cnt        <= '0;
            gnt_idx    <= arb_idx;
            gnt_oh     <= arb_grant;
            acc_we     <= sel_we;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            mem_sfr_n  <= ~sel_sfr;
            // Write dominates; psen only selects code space for reads.
            mem_we_n   <= ~sel_we;
            mem_psen_n <= ~(~sel_we & sel_psen);
            mem_rd_n   <= ~(~sel_we & ~sel_psen);
          end
        end
        BIU_ACCESS: begin
          cnt <= cnt + CW'(1);
          if (mem_data_rdy || (TO_EN && (cnt == CNT_LAST))) begin
            mem_we_n   <= 1'b1;
            mem_rd_n   <= 1'b1;
            mem_psen_n <= 1'b1;
            mem_sfr_n  <= 1'b1;
            // Ready beats a timeout landing in the same cycle.
            if (mem_data_rdy) begin
              state <= BIU_DONE;
              o_ack <= gnt_oh;
              if (!acc_we) begin
                o_rdata <= mem_rdata;
              end
            end else begin
              state <= BIU_ERR;
              o_err <= gnt_oh;
            end
          end
        end
        BIU_DONE, BIU_ERR: begin
          state  <= BIU_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= BIU_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
